// File: rtl/mc_mem_port.sv
// mc_mem_port: wait-state memory port for the multi-cycle ARM core.
// Holds a unified instruction/data word RAM and answers each access with a
// req/ready handshake after a configurable number of wait cycles.
//
// Parameters: DATA_W (multiple of 8), ADDR_W (byte address), DEPTH (words),
//             WAIT_CYCLES (0..15 extra cycles between accept and response).
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   req        access request, sampled only while idle
//   MemWrite   1 = write, 0 = read (sampled with req)
//   Adr        byte address (sampled with req)
//   WriteData  write data (sampled with req)
//   ByteEn     per-byte write enable (sampled with req, ignored on reads)
//   ReadData   registered read data, valid while ready = 1
//   ready      one-cycle response pulse
//   busy       access in flight, core must hold its state
//   err        pulses with ready on a misaligned or out-of-range access
// Optional macro MC_MEM_PERF_EN adds rd_count, wr_count and stall_count
// saturating performance counters.
module mc_mem_port #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                MemWrite,
    input  logic [ADDR_W-1:0]   Adr,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic [DATA_W/8-1:0] ByteEn,
    output logic [DATA_W-1:0]   ReadData,
    output logic                ready,
    output logic                busy,
    output logic                err
`ifdef MC_MEM_PERF_EN
    ,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count,
    output logic [31:0]         stall_count
`endif
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF_W = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic                ill_q;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       be_q;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Address decode of the incoming request
    logic [ADDR_W-1:0]   word_idx_in;
    logic                ill_in;
    logic [IDX_W-1:0]    idx_in;

    assign word_idx_in = Adr >> OFF_W;
    assign ill_in      = (|(Adr & OFF_MASK)) || (word_idx_in >= ADDR_W'(DEPTH));
    assign idx_in      = word_idx_in[IDX_W-1:0];

    // Operation that is about to enter RESP: with zero wait cycles the
    // transition happens straight from IDLE, before anything is latched,
    // so the live inputs must be used there.
    logic                ent_we;
    logic                ent_ill;
    logic [IDX_W-1:0]    ent_idx;

    assign ent_we  = (state_q == S_IDLE) ? MemWrite : we_q;
    assign ent_ill = (state_q == S_IDLE) ? ill_in   : ill_q;
    assign ent_idx = (state_q == S_IDLE) ? idx_in   : idx_q;

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        busy    = 1'b0;
        ready   = 1'b0;
        err     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                busy    = 1'b1;
                ready   = 1'b1;
                err     = ill_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Read data is loaded on the edge entering RESP
        if ((state_d == S_RESP) && (state_q != S_RESP) && !ent_we) begin
            rdata_d = ent_ill ? '0 : mem_q[ent_idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            if ((state_q == S_IDLE) && req) begin
                we_q    <= MemWrite;
                ill_q   <= ill_in;
                idx_q   <= idx_in;
                wdata_q <= WriteData;
                be_q    <= ByteEn;
            end
        end
    end

    // RAM is not reset; a write commits on the edge leaving RESP. Reset
    // forces the state out of RESP asynchronously, which drops a pending write.
    always_ff @(posedge clk) begin
        if ((state_q == S_RESP) && we_q && !ill_q) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be_q[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign ReadData = rdata_q;

`ifdef MC_MEM_PERF_EN
    logic [31:0] rd_cnt_q, wr_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            if ((state_q == S_RESP) && !ill_q) begin
                if (we_q) begin
                    if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
                end else begin
                    if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
                end
            end
            if (busy && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mc_mem_port.sv
// Self-checking bench for mc_mem_port: two instances (WAIT_CYCLES = 2 and 0)
// share stimulus; sel picks which one receives req. A transaction-level model
// predicts busy/ready/err/ReadData every cycle for the selected instance.
module tb_mc_mem_port;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Adr = '0;
    logic [31:0] WriteData = '0;
    logic [3:0]  ByteEn = '0;
    logic        sel = 1'b0;

    logic        req2, req0;
    logic [31:0] rd2, rd0;
    logic        rdy2, rdy0, busy2, busy0, err2, err0;
    logic [31:0] rd_s;
    logic        rdy_s, busy_s, err_s;

`ifdef MC_MEM_PERF_EN
    logic [31:0] rdc2, wrc2, stc2, rdc0, wrc0, stc0;
`endif

    assign req2   = req & ~sel;
    assign req0   = req & sel;
    assign rd_s   = sel ? rd0   : rd2;
    assign rdy_s  = sel ? rdy0  : rdy2;
    assign busy_s = sel ? busy0 : busy2;
    assign err_s  = sel ? err0  : err2;

    always #5 clk = ~clk;

    mc_mem_port #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .req(req2), .MemWrite(MemWrite), .Adr(Adr),
        .WriteData(WriteData), .ByteEn(ByteEn), .ReadData(rd2), .ready(rdy2),
        .busy(busy2), .err(err2)
`ifdef MC_MEM_PERF_EN
        , .rd_count(rdc2), .wr_count(wrc2), .stall_count(stc2)
`endif
    );

    mc_mem_port #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .MemWrite(MemWrite), .Adr(Adr),
        .WriteData(WriteData), .ByteEn(ByteEn), .ReadData(rd0), .ready(rdy0),
        .busy(busy0), .err(err0)
`ifdef MC_MEM_PERF_EN
        , .rd_count(rdc0), .wr_count(wrc0), .stall_count(stc0)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wcur();
        return sel ? 0 : 2;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] mm [2][64];
    logic [31:0] exp_rdv [2] = '{32'd0, 32'd0};
    bit          txn = 0;
    longint      ecnt = 0, resp_at = 0, free_at = 0;
    bit          m_we = 0, m_ill = 0;
    int          m_idx = 0;
    logic [31:0] m_wd = '0;
    logic [3:0]  m_be = '0;
    int unsigned m_rdc = 0, m_wrc = 0, m_stall = 0;

    // A transaction accepted at edge a is busy through edge count a+W,
    // responds when the edge count equals a+W, commits at a+W+1 and
    // the next accept can happen no earlier than a+W+2.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            txn = 0;
            exp_rdv[0] = '0;
            exp_rdv[1] = '0;
            m_rdc = 0; m_wrc = 0; m_stall = 0;
        end else begin
            if (!sel && txn && ecnt <= resp_at) m_stall++;
            ecnt++;
            if (txn && ecnt == resp_at + 1 && !m_ill) begin
                if (m_we) begin
                    for (int b = 0; b < 4; b++)
                        if (m_be[b]) mm[sel][m_idx][8*b +: 8] = m_wd[8*b +: 8];
                    if (!sel) m_wrc++;
                end else if (!sel) begin
                    m_rdc++;
                end
            end
            if ((!txn || ecnt >= free_at) && req === 1'b1) begin
                txn     = 1;
                resp_at = ecnt + wcur();
                free_at = ecnt + wcur() + 2;
                m_we    = MemWrite;
                m_ill   = (Adr % 4 != 0) || ((Adr / 4) >= 64);
                m_idx   = int'(Adr / 4) % 64;
                m_wd    = WriteData;
                m_be    = ByteEn;
            end
            if (txn && ecnt == resp_at && !m_we)
                exp_rdv[sel] = m_ill ? 32'd0 : mm[sel][m_idx];
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_on = 0;
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("busy",     {31'd0, busy_s}, {31'd0, txn && ecnt <= resp_at});
            chk("ready",    {31'd0, rdy_s},  {31'd0, txn && ecnt == resp_at});
            chk("err",      {31'd0, err_s},  {31'd0, txn && ecnt == resp_at && m_ill});
            chk("ReadData", rd_s, exp_rdv[sel]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic txn_do(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rd, output logic e);
        int lat;
        lat = 0; rd = '0; e = 1'b0;
        @(negedge clk);
        req = 1'b1; MemWrite = we; Adr = a; WriteData = wd; ByteEn = be;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (rdy_s) begin
                lat = n; rd = rd_s; e = err_s; req = 1'b0;
            end else begin
                // anything on the inputs while waiting must be ignored
                req = 1'($urandom_range(0, 1));
                MemWrite = 1'($urandom_range(0, 1));
                Adr = $urandom; WriteData = $urandom; ByteEn = 4'($urandom);
            end
        end
        req = 1'b0;
        chk("latency", 32'(lat), 32'(wcur() + 1));
    endtask

    function automatic logic [31:0] rand_adr();
        case ($urandom_range(0, 7))
            0:       return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
            1:       return 32'($urandom_range(64, 1023)) << 2;
            default: return 32'($urandom_range(0, 63)) << 2;
        endcase
    endfunction

    logic [31:0] rd;
    logic        e;
    int          readies, busys;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy",  {31'd0, busy2}, 32'd0);
        chk("rst_ready", {31'd0, rdy2},  32'd0);
        chk("rst_err",   {31'd0, err2},  32'd0);
        chk("rst_rdata", rd2,            32'd0);
        chk("rst_rdata0", rd0,           32'd0);
        chk_on = 1;
        reset = 1'b0;

        // known contents in both RAMs
        for (int s = 0; s < 2; s++) begin
            @(negedge clk); #1 sel = 1'(s);
            for (int i = 0; i < 64; i++) txn_do(1'b1, 32'(i * 4), $urandom, 4'hF, rd, e);
        end
        @(negedge clk); #1 sel = 1'b0;

        // write then read back
        txn_do(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e);
        chk("wr_err", {31'd0, e}, 32'd0);
        txn_do(1'b0, 32'h10, 32'h0, 4'h0, rd, e);
        chk("rd_data", rd, 32'hDEADBEEF);
        chk("rd_err", {31'd0, e}, 32'd0);

        // byte lanes
        txn_do(1'b1, 32'h20, 32'h11223344, 4'hF, rd, e);
        txn_do(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, e);
        txn_do(1'b0, 32'h20, 32'h0, 4'h0, rd, e);
        chk("byte_lanes", rd, 32'h11BB33DD);

        // illegal accesses
        txn_do(1'b0, 32'h02, 32'h0, 4'h0, rd, e);
        chk("mis_err", {31'd0, e}, 32'd1);
        chk("mis_rdata", rd, 32'd0);
        txn_do(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, e);
        txn_do(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, rd, e);
        chk("oor_err", {31'd0, e}, 32'd1);
        txn_do(1'b0, 32'h0, 32'h0, 4'h0, rd, e);
        chk("oor_word0", rd, 32'hCAFEF00D);

        // reset during WAIT of a write
        txn_do(1'b1, 32'h08, 32'h0BADF00D, 4'hF, rd, e);
        @(negedge clk);
        req = 1'b1; MemWrite = 1'b1; Adr = 32'h08; WriteData = 32'h55; ByteEn = 4'hF;
        @(negedge clk);
        req = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("arst_busy",  {31'd0, busy2}, 32'd0);
        chk("arst_ready", {31'd0, rdy2},  32'd0);
        chk("arst_rdata", rd2,            32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        txn_do(1'b0, 32'h08, 32'h0, 4'h0, rd, e);
        chk("arst_old", rd, 32'h0BADF00D);

        // randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            @(negedge clk); #1 sel = 1'(s);
            for (int i = 0; i < 60; i++)
                txn_do(1'($urandom_range(0, 1)), rand_adr(), $urandom, 4'($urandom), rd, e);
        end

        // zero wait with req held high
        @(negedge clk); #1 sel = 1'b1;
        @(negedge clk);
        readies = 0; busys = 0;
        req = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            MemWrite = 1'($urandom_range(0, 1));
            Adr = 32'($urandom_range(0, 63)) << 2;
            WriteData = $urandom; ByteEn = 4'($urandom);
            @(negedge clk);
            if (rdy0) readies++;
            if (busy0) busys++;
        end
        req = 1'b0;
        chk("zw_readies", 32'(readies), 32'd10);
        chk("zw_busy",    32'(busys),   32'd10);
        txn_do(1'b0, 32'h0, 32'h0, 4'h0, rd, e);

`ifdef MC_MEM_PERF_EN
        @(negedge clk); #1 sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rd_count",    rdc2, 32'(m_rdc));
        chk("wr_count",    wrc2, 32'(m_wrc));
        chk("stall_count", stc2, 32'(m_stall));
`endif

        repeat (3) @(negedge clk);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
